// File: rtl/cmap_pkg.sv
// Shared types and default colours for the pipelined colour mapper.
package cmap_pkg;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_bytes_t;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_HIDDEN  = 1'b1
    } blink_phase_t;

    localparam rgb_t SKY_RGB_DEF    = 24'hD2E6FF;
    localparam rgb_t KEY_RGB_DEF    = 24'hFFFFFF;
    localparam rgb_t CURSOR_RGB_DEF = 24'hFF0000;

    // Split a packed 24-bit colour into its R/G/B bytes (R in the MSBs).
    function automatic rgb_bytes_t rgb_split(input rgb_t c);
        rgb_bytes_t s;
        s.r = c[23:16];
        s.g = c[15:8];
        s.b = c[7:0];
        return s;
    endfunction

endpackage

// File: rtl/pipelined_color_mapper_if.sv
// Pixel stream into the colour mapper and composed VGA colour out of it.
interface pipelined_color_mapper_if #(
    parameter int unsigned NUM_LAYERS = 2
);
    logic                         frame_start;
    logic                         pix_valid;
    logic [9:0]                   DrawX;
    logic [9:0]                   DrawY;
    logic [9:0]                   MouseX;
    logic [9:0]                   MouseY;
    logic                         cursor_en;
    logic [NUM_LAYERS-1:0]        layer_hit;
    logic [24*NUM_LAYERS-1:0]     layer_rgb;
    logic                         out_valid;
    logic [7:0]                   VGA_R;
    logic [7:0]                   VGA_G;
    logic [7:0]                   VGA_B;

    modport master (
        output frame_start, pix_valid, DrawX, DrawY, MouseX, MouseY,
               cursor_en, layer_hit, layer_rgb,
        input  out_valid, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  frame_start, pix_valid, DrawX, DrawY, MouseX, MouseY,
               cursor_en, layer_hit, layer_rgb,
        output out_valid, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/cursor_frame_ctrl.sv
// Frame-synchronous cursor shadow registers with same-cycle bypass and blink phase.
module cursor_frame_ctrl
    import cmap_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic       cursor_en,
    output logic [9:0] mouse_x_eff,
    output logic [9:0] mouse_y_eff,
    output logic       cursor_vis_eff
);

    localparam int unsigned BF   = (BLINK_FRAMES > 0) ? BLINK_FRAMES : 1;
    localparam int unsigned CW   = (BF > 1) ? $clog2(BF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BF - 1);

    blink_phase_t  phase, phase_next;
    logic [CW-1:0] blink_cnt, blink_cnt_next;
    logic [9:0]    shadow_x, shadow_x_next;
    logic [9:0]    shadow_y, shadow_y_next;
    logic          shadow_vis, shadow_vis_next;
    logic          vis_now;

    // State register: blink phase/counter and per-frame cursor shadow.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase      <= PH_VISIBLE;
            blink_cnt  <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            shadow_vis <= 1'b0;
        end else begin
            phase      <= phase_next;
            blink_cnt  <= blink_cnt_next;
            shadow_x   <= shadow_x_next;
            shadow_y   <= shadow_y_next;
            shadow_vis <= shadow_vis_next;
        end
    end

    // Next state: advance blink on frame_start, capture cursor for the new frame.
    // The frame's visibility uses the phase held before this frame_start's toggle,
    // so a whole frame (including its first pixel) sees one consistent phase.
    always_comb begin
        phase_next      = phase;
        blink_cnt_next  = blink_cnt;
        shadow_x_next   = shadow_x;
        shadow_y_next   = shadow_y;
        shadow_vis_next = shadow_vis;
        if (frame_start) begin
            shadow_x_next   = mouse_x;
            shadow_y_next   = mouse_y;
            shadow_vis_next = vis_now;
            if (BLINK_FRAMES > 0) begin
                if (blink_cnt == LAST) begin
                    blink_cnt_next = '0;
                    phase_next     = (phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
                end else begin
                    blink_cnt_next = blink_cnt + 1'b1;
                end
            end
        end
    end

    // Outputs: bypass live values in the frame_start cycle, shadow otherwise.
    always_comb begin
        vis_now        = cursor_en && (phase == PH_VISIBLE);
        mouse_x_eff    = frame_start ? mouse_x : shadow_x;
        mouse_y_eff    = frame_start ? mouse_y : shadow_y;
        cursor_vis_eff = frame_start ? vis_now : shadow_vis;
    end

endmodule

// File: rtl/pipelined_color_mapper.sv
// Three-stage per-pixel compositor: layers, round cursor and sky colour.
module pipelined_color_mapper
    import cmap_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned NUM_LAYERS   = 2,
    parameter int unsigned CURSOR_R     = 2,
    parameter rgb_t        CURSOR_RGB   = CURSOR_RGB_DEF,
    parameter rgb_t        SKY_RGB      = SKY_RGB_DEF,
    parameter rgb_t        KEY_RGB      = KEY_RGB_DEF,
    parameter int unsigned BLINK_FRAMES = 0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    pipelined_color_mapper_if.slave    bus
);

    localparam logic [21:0] R2 = 22'(CURSOR_R * CURSOR_R);

    logic [9:0] mouse_x_eff;
    logic [9:0] mouse_y_eff;
    logic       cursor_vis_eff;

    cursor_frame_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_cursor (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_start    (bus.frame_start),
        .mouse_x        (bus.MouseX),
        .mouse_y        (bus.MouseY),
        .cursor_en      (bus.cursor_en),
        .mouse_x_eff    (mouse_x_eff),
        .mouse_y_eff    (mouse_y_eff),
        .cursor_vis_eff (cursor_vis_eff)
    );

    // Stage 1 combinational terms
    logic signed [10:0] dx_c, dy_c;
    logic               active_c;

    // Stage 1 registers
    logic                      s1_valid, s1_active, s1_vis;
    logic signed [10:0]        s1_dx, s1_dy;
    logic [NUM_LAYERS-1:0]     s1_hit;
    logic [24*NUM_LAYERS-1:0]  s1_rgb;

    // Stage 2 combinational terms
    logic signed [21:0] dx_w, dy_w;
    logic [21:0]        d2_c;
    logic               cur_hit_c, any_hit_c;
    rgb_t               sel_rgb_c;

    // Stage 2 registers
    logic s2_valid, s2_active, s2_cur_hit, s2_any_hit;
    rgb_t s2_sel_rgb;

    // Stage 3 colour
    rgb_t       pix_c;
    rgb_bytes_t pix_bytes;

    // Stage 1 math: signed distance to the effective cursor and visibility.
    always_comb begin
        dx_c     = $signed({1'b0, bus.DrawX}) - $signed({1'b0, mouse_x_eff});
        dy_c     = $signed({1'b0, bus.DrawY}) - $signed({1'b0, mouse_y_eff});
        active_c = (32'(bus.DrawX) < H_ACTIVE) && (32'(bus.DrawY) < V_ACTIVE);
    end

    // Valid pipeline: reset drops any in-flight pixels.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= bus.pix_valid;
            s2_valid <= s1_valid;
        end
    end

    // Stage 1 data register.
    always_ff @(posedge Clk) begin
        s1_active <= active_c;
        s1_vis    <= cursor_vis_eff;
        s1_dx     <= dx_c;
        s1_dy     <= dy_c;
        s1_hit    <= bus.layer_hit;
        s1_rgb    <= bus.layer_rgb;
    end

    // Stage 2 math: squared distance and highest-priority opaque layer.
    always_comb begin
        dx_w      = 22'(s1_dx);
        dy_w      = 22'(s1_dy);
        d2_c      = unsigned'(dx_w * dx_w + dy_w * dy_w);
        cur_hit_c = s1_vis && (d2_c <= R2);
        any_hit_c = 1'b0;
        sel_rgb_c = SKY_RGB;
        for (int unsigned i = NUM_LAYERS; i > 0; i--) begin
            if (s1_hit[i-1] && (s1_rgb[24*(i-1) +: 24] != KEY_RGB)) begin
                any_hit_c = 1'b1;
                sel_rgb_c = s1_rgb[24*(i-1) +: 24];
            end
        end
    end

    // Stage 2 data register.
    always_ff @(posedge Clk) begin
        s2_active  <= s1_active;
        s2_cur_hit <= cur_hit_c;
        s2_any_hit <= any_hit_c;
        s2_sel_rgb <= sel_rgb_c;
    end

    // Stage 3 priority: blanking, cursor, layer, sky.
    always_comb begin
        if (!s2_active)      pix_c = SKY_RGB;
        else if (s2_cur_hit) pix_c = CURSOR_RGB;
        else if (s2_any_hit) pix_c = s2_sel_rgb;
        else                 pix_c = SKY_RGB;
        pix_bytes = rgb_split(pix_c);
    end

    // Output registers: colour only advances on valid pixels.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.out_valid <= 1'b0;
            bus.VGA_R     <= '0;
            bus.VGA_G     <= '0;
            bus.VGA_B     <= '0;
        end else begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.VGA_R <= pix_bytes.r;
                bus.VGA_G <= pix_bytes.g;
                bus.VGA_B <= pix_bytes.b;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_color_mapper.sv
// Directed bench for pipelined_color_mapper: table vectors plus reset, streaming and blink sequences.
module tb_pipelined_color_mapper;

    localparam logic [23:0] SKY = 24'hD2E6FF;
    localparam logic [23:0] CUR = 24'hFF0000;
    localparam logic [23:0] KEY = 24'hFFFFFF;

    typedef struct {
        bit          fs;
        logic [9:0]  mx, my;
        bit          en;
        logic [9:0]  x, y;
        logic [1:0]  hit;
        logic [23:0] rgb0, rgb1;
        logic [23:0] exp;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    always #5 Clk = ~Clk;

    pipelined_color_mapper_if #(.NUM_LAYERS(2)) bus ();
    pipelined_color_mapper_if #(.NUM_LAYERS(2)) bus_b ();

    pipelined_color_mapper #(.NUM_LAYERS(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    pipelined_color_mapper #(.NUM_LAYERS(2), .BLINK_FRAMES(2)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_b)
    );

    assign bus_b.frame_start = bus.frame_start;
    assign bus_b.pix_valid   = bus.pix_valid;
    assign bus_b.DrawX       = bus.DrawX;
    assign bus_b.DrawY       = bus.DrawY;
    assign bus_b.MouseX      = bus.MouseX;
    assign bus_b.MouseY      = bus.MouseY;
    assign bus_b.cursor_en   = bus.cursor_en;
    assign bus_b.layer_hit   = bus.layer_hit;
    assign bus_b.layer_rgb   = bus.layer_rgb;

    function automatic vec_t mk(bit fs, int mx, int my, bit en, int x, int y,
                                logic [1:0] hit, logic [23:0] rgb0, logic [23:0] rgb1,
                                logic [23:0] exp);
        vec_t v;
        v.fs = fs; v.mx = 10'(mx); v.my = 10'(my); v.en = en;
        v.x = 10'(x); v.y = 10'(y); v.hit = hit; v.rgb0 = rgb0; v.rgb1 = rgb1;
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit valid);
        bus.frame_start = v.fs;
        bus.pix_valid   = valid;
        bus.MouseX      = v.mx;
        bus.MouseY      = v.my;
        bus.cursor_en   = v.en;
        bus.DrawX       = v.x;
        bus.DrawY       = v.y;
        bus.layer_hit   = v.hit;
        bus.layer_rgb   = {v.rgb1, v.rgb0};
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_rgb(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    // One isolated pixel: drive, idle, then check the output three edges later.
    task automatic run_one(input vec_t v, input bit use_b, input string name);
        logic        ov;
        logic [23:0] rgb;
        @(negedge Clk);
        drive(v, 1'b1);
        @(negedge Clk);
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        ov  = use_b ? bus_b.out_valid : bus.out_valid;
        rgb = use_b ? {bus_b.VGA_R, bus_b.VGA_G, bus_b.VGA_B}
                    : {bus.VGA_R, bus.VGA_G, bus.VGA_B};
        check_bit({name, "_valid"}, ov, 1'b1);
        check_rgb(name, rgb, v.exp);
    endtask

    vec_t tbl[22];
    vec_t strm[6];
    vec_t idle;
    logic [23:0] expq[$];

    initial begin
        idle = mk(0, 0, 0, 0, 5, 5, 2'b00, 24'h0, 24'h0, SKY);
        drive(idle, 1'b0);

        tbl[0]  = mk(1, 100, 100, 1, 102, 100, 2'b00, 24'h0, 24'h0, CUR);
        tbl[1]  = mk(0, 100, 100, 1, 102, 101, 2'b00, 24'h0, 24'h0, SKY);
        tbl[2]  = mk(0, 100, 100, 1, 101, 101, 2'b00, 24'h0, 24'h0, CUR);
        tbl[3]  = mk(0, 100, 100, 1, 100, 100, 2'b00, 24'h0, 24'h0, CUR);
        tbl[4]  = mk(0, 100, 100, 1,  97, 100, 2'b00, 24'h0, 24'h0, SKY);
        tbl[5]  = mk(0, 200, 200, 1, 200, 200, 2'b00, 24'h0, 24'h0, SKY);
        tbl[6]  = mk(0, 200, 200, 1, 100, 100, 2'b00, 24'h0, 24'h0, CUR);
        tbl[7]  = mk(1, 200, 200, 1, 200, 200, 2'b00, 24'h0, 24'h0, CUR);
        tbl[8]  = mk(0, 300, 300, 1, 201, 201, 2'b00, 24'h0, 24'h0, CUR);
        tbl[9]  = mk(0, 300, 300, 1,  10,  10, 2'b11, KEY, 24'h123456, 24'h123456);
        tbl[10] = mk(0, 300, 300, 1,  10,  10, 2'b11, 24'h00FF00, 24'h123456, 24'h00FF00);
        tbl[11] = mk(0, 300, 300, 1,  10,  10, 2'b10, 24'h00FF00, 24'h123456, 24'h123456);
        tbl[12] = mk(0, 300, 300, 1,  10,  10, 2'b01, KEY, 24'h123456, SKY);
        tbl[13] = mk(0, 300, 300, 1, 200, 201, 2'b11, 24'h00FF00, 24'h123456, CUR);
        tbl[14] = mk(0, 300, 300, 1, 640,  10, 2'b11, 24'h00FF00, 24'h123456, SKY);
        tbl[15] = mk(0, 300, 300, 1,  10, 480, 2'b11, 24'h00FF00, 24'h123456, SKY);
        tbl[16] = mk(0, 300, 300, 1, 639, 479, 2'b01, 24'h00FF00, 24'h123456, 24'h00FF00);
        tbl[17] = mk(1, 641,  10, 1, 639,  10, 2'b00, 24'h0, 24'h0, CUR);
        tbl[18] = mk(0, 641,  10, 1, 640,  10, 2'b01, 24'h00FF00, 24'h0, SKY);
        tbl[19] = mk(1,   0,   0, 1,   0,   2, 2'b00, 24'h0, 24'h0, CUR);
        tbl[20] = mk(1,   0,   0, 0,   0,   0, 2'b00, 24'h0, 24'h0, SKY);
        tbl[21] = mk(0,   0,   0, 1,   0,   0, 2'b00, 24'h0, 24'h0, SKY);

        strm[0] = mk(1, 50, 50, 1,  50,  50, 2'b00, 24'h0, 24'h0, CUR);
        strm[1] = mk(0, 50, 50, 1,  52,  50, 2'b00, 24'h0, 24'h0, CUR);
        strm[2] = mk(0, 50, 50, 1,  53,  50, 2'b00, 24'h0, 24'h0, SKY);
        strm[3] = mk(0, 50, 50, 1,  50,  48, 2'b00, 24'h0, 24'h0, CUR);
        strm[4] = mk(0, 50, 50, 1,  10,  10, 2'b01, 24'hABCDEF, 24'h0, 24'hABCDEF);
        strm[5] = mk(0, 50, 50, 1, 700,  10, 2'b11, 24'hABCDEF, 24'h0, SKY);

        // Reset held two cycles with pix_valid high.
        @(negedge Clk);
        Reset = 1'b1;
        drive(idle, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check_bit("rst_valid", bus.out_valid, 1'b0);
            check_rgb("rst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 24'h0);
        end
        Reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            check_bit("post_rst_valid", bus.out_valid, (i == 3));
        end
        check_rgb("post_rst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, SKY);
        bus.pix_valid = 1'b0;
        repeat (4) @(negedge Clk);
        check_bit("drain_valid", bus.out_valid, 1'b0);
        check_rgb("hold_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, SKY);

        // Table of isolated pixels.
        for (int i = 0; i < 22; i++)
            run_one(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Back-to-back stream: one pixel per cycle, exact 3-cycle latency.
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            check_bit($sformatf("strm_valid%0d", i), bus.out_valid, (i >= 3 && i < 9));
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL strm_extra: got output expected none");
                end else begin
                    check_rgb($sformatf("strm_rgb%0d", i), {bus.VGA_R, bus.VGA_G, bus.VGA_B},
                              expq.pop_front());
                end
            end
            if (i < 6) begin
                drive(strm[i], 1'b1);
                expq.push_back(strm[i].exp);
            end else begin
                drive(idle, 1'b0);
            end
        end
        @(negedge Clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL strm_count: got %0d leftover expected 0", expq.size());
        end

        // Mid-frame reset drops an in-flight pixel and clears the latched cursor.
        drive(tbl[3], 1'b1);
        bus.frame_start = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        drive(idle, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_bit("midrst_valid", bus.out_valid, 1'b0);
            @(negedge Clk);
        end
        check_rgb("midrst_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 24'h0);
        run_one(mk(0, 100, 100, 1, 100, 100, 2'b00, 24'h0, 24'h0, SKY), 1'b0, "midrst_cursor_cleared");

        // Blink with BLINK_FRAMES=2: visible in frames 0-1, hidden 2-3, visible 4.
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [23:0] e;
            e = (k == 2 || k == 3) ? SKY : CUR;
            run_one(mk(1, 100, 100, 1, 100, 100, 2'b00, 24'h0, 24'h0, e), 1'b1,
                    $sformatf("blink_f%0d_first", k));
            run_one(mk(0, 100, 100, 1, 101, 100, 2'b00, 24'h0, 24'h0, e), 1'b1,
                    $sformatf("blink_f%0d_mid", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
